// File: rtl/led_blink_driver.sv
// Per-channel LED blink sequencer: each one-cycle trigger pulse starts a run of
// BLINKS lit phases of ON_TIME cycles, separated by dark phases of OFF_TIME cycles.
module led_blink_driver #(
  parameter int CH_W           = 2,
  parameter int ON_TIME        = 5_000_000,
  parameter int OFF_TIME       = 5_000_000,
  parameter int BLINKS         = 3,
  parameter int LED_ACTIVE_LOW = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH_W-1:0] trig,
  output logic [CH_W-1:0] led,
  output logic [CH_W-1:0] busy
);

  localparam int MAX_T = (ON_TIME > OFF_TIME) ? ON_TIME : OFF_TIME;
  localparam int PH_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam int BL_W  = $clog2(BLINKS + 1);

  localparam logic [PH_W-1:0] ON_LAST  = PH_W'(ON_TIME - 1);
  localparam logic [PH_W-1:0] OFF_LAST = PH_W'(OFF_TIME - 1);
  localparam logic [BL_W-1:0] BL_LAST  = BL_W'(BLINKS);
  localparam logic [PH_W-1:0] PH_ONE   = PH_W'(1);
  localparam logic [BL_W-1:0] BL_ONE   = BL_W'(1);

  // Pin level that lights the LED; the dark level is its complement.
  localparam logic LIT  = (LED_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic DARK = ~LIT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  genvar gi;
  generate
    for (gi = 0; gi < CH_W; gi++) begin : g_ch
      state_t          state_reg;
      logic [PH_W-1:0] phase_reg;
      logic [BL_W-1:0] blink_reg;
      logic            led_reg;
      logic            busy_reg;

      // Outputs are updated alongside the state so they track it with no
      // combinational path from trig; a trigger always restarts the run.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg <= IDLE;
          phase_reg <= '0;
          blink_reg <= '0;
          led_reg   <= DARK;
          busy_reg  <= 1'b0;
        end else if (trig[gi]) begin
          state_reg <= ON;
          phase_reg <= '0;
          blink_reg <= BL_ONE;
          led_reg   <= LIT;
          busy_reg  <= 1'b1;
        end else begin
          case (state_reg)
            IDLE: begin
              led_reg  <= DARK;
              busy_reg <= 1'b0;
            end
            ON: begin
              if (phase_reg == ON_LAST) begin
                phase_reg <= '0;
                led_reg   <= DARK;
                if (blink_reg == BL_LAST) begin
                  state_reg <= IDLE;
                  blink_reg <= '0;
                  busy_reg  <= 1'b0;
                end else begin
                  state_reg <= OFF;
                end
              end else begin
                phase_reg <= phase_reg + PH_ONE;
              end
            end
            OFF: begin
              if (phase_reg == OFF_LAST) begin
                state_reg <= ON;
                phase_reg <= '0;
                blink_reg <= blink_reg + BL_ONE;
                led_reg   <= LIT;
              end else begin
                phase_reg <= phase_reg + PH_ONE;
              end
            end
            default: begin
              state_reg <= IDLE;
              phase_reg <= '0;
              blink_reg <= '0;
              led_reg   <= DARK;
              busy_reg  <= 1'b0;
            end
          endcase
        end
      end

      assign led[gi]  = led_reg;
      assign busy[gi] = busy_reg;
    end
  endgenerate

endmodule

// File: tb/tb_led_blink_driver.sv
// Bench for led_blink_driver: three instances (base, BLINKS=1, active-high LED)
// share stimulus; an age-based reference model feeds a per-cycle scoreboard.
module tb_led_blink_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] trig = 2'b00;
  logic [1:0] led_a, busy_a, led_b, busy_b, led_c, busy_c;

  int total = 0;
  int bad   = 0;

  logic [11:0] sb[$];

  // Reference model: a channel is active for TOTAL cycles after its latest
  // trigger and lit while (age mod (ON+OFF)) < ON.
  int  age[3][2];
  bit  act[3][2];
  int  tot_t[3] = '{11, 4, 11};
  bit  al_t[3]  = '{1'b1, 1'b1, 1'b0};

  always #5 clk = ~clk;

  led_blink_driver #(.CH_W(2), .ON_TIME(4), .OFF_TIME(3), .BLINKS(2), .LED_ACTIVE_LOW(1))
    dut_a (.clk(clk), .rst(rst), .trig(trig), .led(led_a), .busy(busy_a));
  led_blink_driver #(.CH_W(2), .ON_TIME(4), .OFF_TIME(3), .BLINKS(1), .LED_ACTIVE_LOW(1))
    dut_b (.clk(clk), .rst(rst), .trig(trig), .led(led_b), .busy(busy_b));
  led_blink_driver #(.CH_W(2), .ON_TIME(4), .OFF_TIME(3), .BLINKS(2), .LED_ACTIVE_LOW(0))
    dut_c (.clk(clk), .rst(rst), .trig(trig), .led(led_c), .busy(busy_c));

  // Drive one cycle of stimulus, push the model's post-edge expectation, clock.
  task automatic apply(input logic r, input logic [1:0] t);
    logic [1:0] l[3];
    logic [1:0] b[3];
    bit on;
    rst  = r;
    trig = t;
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 2; c++) begin
        if (r) begin
          act[d][c] = 1'b0;
          age[d][c] = 0;
        end else if (t[c]) begin
          act[d][c] = 1'b1;
          age[d][c] = 0;
        end else if (act[d][c]) begin
          age[d][c]++;
          if (age[d][c] >= tot_t[d]) act[d][c] = 1'b0;
        end
        on = act[d][c] && ((age[d][c] % 7) < 4);
        l[d][c] = al_t[d] ? ~on : on;
        b[d][c] = act[d][c];
      end
    end
    sb.push_back({l[0], b[0], l[1], b[1], l[2], b[2]});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] got, e;
    for (int k = 0; k < 15; k++) begin
      apply(k < 3, (k < 3) ? ((k % 2 == 0) ? 2'b11 : 2'b01) : 2'b00);
      got = {led_a, busy_a, led_b, busy_b, led_c, busy_c};
      e = sb.pop_front();
      total++;
      $display("txn reset k=%0d got=%h exp=%h", k, got, e);
      if (got !== e) begin
        bad++;
        $display("FAIL reset_sb k=%0d got=%h exp=%h", k, got, e);
      end
      total++;
      if (led_a !== 2'b11 || busy_a !== 2'b00 || led_c !== 2'b00) begin
        bad++;
        $display("FAIL reset_idle k=%0d led_a=%b busy_a=%b led_c=%b exp 11/00/00", k, led_a, busy_a, led_c);
      end
    end
  endtask

  task automatic test_single();
    logic [11:0] got, e;
    int na = 0, nb = 0, na1 = 0;
    for (int k = 0; k < 14; k++) begin
      apply(1'b0, (k == 0) ? 2'b01 : 2'b00);
      got = {led_a, busy_a, led_b, busy_b, led_c, busy_c};
      e = sb.pop_front();
      total++;
      $display("txn single k=%0d got=%h exp=%h", k, got, e);
      if (got !== e) begin
        bad++;
        $display("FAIL single_sb k=%0d got=%h exp=%h", k, got, e);
      end
      if (busy_a[0]) na++;
      if (busy_b[0]) nb++;
      if (busy_a[1] || led_a[1] !== 1'b1) na1++;
    end
    total++;
    if (na !== 11) begin bad++; $display("FAIL single_busy_len got=%0d exp=11", na); end
    total++;
    if (nb !== 4) begin bad++; $display("FAIL single_b1_busy_len got=%0d exp=4", nb); end
    total++;
    if (na1 !== 0) begin bad++; $display("FAIL single_ch1_quiet got=%0d exp=0", na1); end
  endtask

  task automatic test_retrigger();
    logic [11:0] got, e;
    int last = -1;
    for (int k = 0; k < 20; k++) begin
      apply(1'b0, (k == 0 || k == 6) ? 2'b01 : 2'b00);
      got = {led_a, busy_a, led_b, busy_b, led_c, busy_c};
      e = sb.pop_front();
      total++;
      $display("txn retrig k=%0d got=%h exp=%h", k, got, e);
      if (got !== e) begin
        bad++;
        $display("FAIL retrig_sb k=%0d got=%h exp=%h", k, got, e);
      end
      if (busy_a[0]) last = k;
    end
    total++;
    if (last !== 16) begin bad++; $display("FAIL retrig_end got=%0d exp=16", last); end
  endtask

  task automatic test_final_cycle();
    logic [11:0] got, e;
    int n = 0;
    for (int k = 0; k < 25; k++) begin
      apply(1'b0, (k == 0 || k == 11) ? 2'b01 : 2'b00);
      got = {led_a, busy_a, led_b, busy_b, led_c, busy_c};
      e = sb.pop_front();
      total++;
      $display("txn final k=%0d got=%h exp=%h", k, got, e);
      if (got !== e) begin
        bad++;
        $display("FAIL final_sb k=%0d got=%h exp=%h", k, got, e);
      end
      if (busy_a[0]) n++;
      if (k == 11) begin
        total++;
        if (led_a[0] !== 1'b0 || busy_a[0] !== 1'b1) begin
          bad++;
          $display("FAIL final_no_gap led=%b busy=%b exp 0/1", led_a[0], busy_a[0]);
        end
      end
    end
    total++;
    if (n !== 22) begin bad++; $display("FAIL final_busy_len got=%0d exp=22", n); end
  endtask

  task automatic test_independent();
    logic [11:0] got, e;
    int n0 = 0, n1 = 0;
    for (int k = 0; k < 18; k++) begin
      apply(1'b0, (k == 0) ? 2'b11 : ((k == 3) ? 2'b01 : 2'b00));
      got = {led_a, busy_a, led_b, busy_b, led_c, busy_c};
      e = sb.pop_front();
      total++;
      $display("txn indep k=%0d got=%h exp=%h", k, got, e);
      if (got !== e) begin
        bad++;
        $display("FAIL indep_sb k=%0d got=%h exp=%h", k, got, e);
      end
      if (busy_a[0]) n0++;
      if (busy_a[1]) n1++;
    end
    total++;
    if (n1 !== 11) begin bad++; $display("FAIL indep_ch1_len got=%0d exp=11", n1); end
    total++;
    if (n0 !== 14) begin bad++; $display("FAIL indep_ch0_len got=%0d exp=14", n0); end
  endtask

  task automatic test_reset_mid();
    logic [11:0] got, e;
    for (int k = 0; k < 10; k++) begin
      apply(k == 5, (k == 0) ? 2'b01 : 2'b00);
      got = {led_a, busy_a, led_b, busy_b, led_c, busy_c};
      e = sb.pop_front();
      total++;
      $display("txn rstmid k=%0d got=%h exp=%h", k, got, e);
      if (got !== e) begin
        bad++;
        $display("FAIL rstmid_sb k=%0d got=%h exp=%h", k, got, e);
      end
      if (k == 5) begin
        total++;
        if (led_a !== 2'b11 || busy_a !== 2'b00) begin
          bad++;
          $display("FAIL rstmid_idle led=%b busy=%b exp 11/00", led_a, busy_a);
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < 2; c++) begin
        age[d][c] = 0;
        act[d][c] = 1'b0;
      end
    test_reset();
    test_single();
    test_retrigger();
    test_final_cycle();
    test_independent();
    test_reset_mid();
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL sb_drain left=%0d exp=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
